dm_arb: RTL and testbench
=========================

DM_ARB -- requirements
Module: dm_arb

Interface
REQ-001 Parameter DM_AW, default 12, memory word-address width (mem_addr = addr[DM_AW+1:2]).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 c_valid/c_we  in  1/1  CPU request valid / store (1) or load (0).
REQ-005 c_addr/c_wdata  in  32/32  CPU byte address / store data (low bits significant for sb/sh).
REQ-006 c_op  in  3  000 word, 001 lbu, 010 lb, 011 lhu, 100 lh; stores use 000 sw, 001/010 sb, 011/100 sh.
REQ-007 c_ready  out  1  CPU request accepted this cycle.
REQ-008 d_valid, d_we, d_addr, d_wdata, d_op, d_ready: second requester (bridge), same widths and meanings.
REQ-009 rsp_valid/rsp_id/rsp_err  out  1/1/1  response strobe / 0=CPU, 1=bridge / alignment or op error.
REQ-010 rsp_data  out  32  raw memory word for loads; 0 for stores and errors.
REQ-011 ext_ad/ext_op  out  2/3  addr[1:0] and op of the responding request, driving the load extender.
REQ-012 mem_en/mem_we  out  1/4  memory cycle enable / byte write enables.
REQ-013 mem_addr/mem_wdata  out  DM_AW/32  word address / lane-aligned write data.
REQ-014 mem_rdata  in  32  synchronous-read data, valid the cycle after a mem_en=1 edge.

Function
REQ-015 FSM states IDLE, ACCESS, RESP; one request in flight max.
REQ-016 c_ready/d_ready SHALL be combinational, high only in IDLE, at most one high per cycle.
REQ-017 Grant: only one valid -> that one; both valid -> requester not granted last (round robin); last-grant register updates on handshake.
REQ-018 Handshake (valid & ready) in IDLE SHALL register we, addr, wdata, op, id; legal request -> ACCESS, error -> RESP.
REQ-019 Error: op in 101-111; word with addr[1:0]!=0; half with addr[0]!=0; error requests issue no memory cycle.
REQ-020 ACCESS: mem_en=1, mem_addr=registered addr[DM_AW+1:2]; loads mem_we=0000; next state RESP.
REQ-021 Store byte enables: sw 1111; sb 0001<<addr[1:0]; sh 0011 (addr[1]=0) or 1100 (addr[1]=1).
REQ-022 mem_wdata: sw wdata; sb {4{wdata[7:0]}}; sh {2{wdata[15:0]}}.
REQ-023 RESP: rsp_valid=1 for exactly one cycle; rsp_data=mem_rdata for legal loads else 0; rsp_err as classified; next state IDLE.
REQ-024 ext_ad/ext_op SHALL hold the registered addr[1:0]/op from handshake until the next handshake.
REQ-025 Latency: handshake in cycle N -> rsp_valid in N+2 (legal) or N+1 (error); new handshake earliest in the cycle after RESP.
REQ-026 Outside ACCESS: mem_en=0, mem_we=0000; outside RESP: rsp_valid=0, rsp_err=0.
REQ-027 Requests whose valid drops before handshake SHALL be ignored without state change.
REQ-028 mem_addr bits above DM_AW+1 SHALL be discarded without error.

Reset
REQ-029 reset low SHALL asynchronously force IDLE, last-grant=bridge (CPU wins first tie), all registers 0.
REQ-030 During reset: c_ready, d_ready, rsp_valid, rsp_err, mem_en 0; mem_we 0000; rsp_data, ext_ad, ext_op, mem_addr, mem_wdata 0.
REQ-031 Reset asserted in ACCESS SHALL drop mem_en/mem_we in the same cycle; no response issued for the aborted request.
REQ-032 After reset release, first handshake possible on the first rising edge with reset high.

Verification
REQ-033 CPU lw addr 0x10, mem word 0x8899AABB -> mem_en at N+1 mem_addr 4, rsp_valid N+2 rsp_id 0 rsp_data 0x8899AABB ext_ad 00 ext_op 000.
REQ-034 Bridge sb addr 0x7 wdata 0x5A -> mem_we 1000, mem_wdata 0x5A5A5A5A, mem_addr 1, rsp_data 0, rsp_err 0.
REQ-035 CPU lh addr 0x3 -> no mem_en, rsp_valid at N+1 rsp_err 1 rsp_data 0; op 110 -> same.
REQ-036 Both valid continuously after reset -> grants C, D, C, D, handshakes every 3 cycles, rsp_id alternates 0,1,0,1.
REQ-037 sh addr 0x2 wdata 0x1234 -> mem_we 1100, mem_wdata 0x12341234; reset low in ACCESS -> mem_en 0 immediately, no rsp_valid, memory word unchanged.

Source files
------------

// File: rtl/dm_arb.sv
// dm_arb: two-requester data-memory arbiter
// (CPU and bridge) with alignment checking,
// byte-lane steering and one request in flight.
//
// Ports:
//   i_clk, i_rst_n      clock, async active-low reset
//   i_c_* / o_c_ready   CPU request and accept
//   i_d_* / o_d_ready   bridge request and accept
//   o_rsp_*             response strobe, id, error, data
//   o_ext_ad/o_ext_op   addr[1:0]/op for load extender
//   o_mem_*             sync-RAM port (en, we, addr, wdata)
//   i_mem_rdata         RAM read data, one cycle after en
module dm_arb #(
  parameter int DM_AW = 12
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_c_valid,
  input  logic             i_c_we,
  input  logic [31:0]      i_c_addr,
  input  logic [31:0]      i_c_wdata,
  input  logic [2:0]       i_c_op,
  output logic             o_c_ready,
  input  logic             i_d_valid,
  input  logic             i_d_we,
  input  logic [31:0]      i_d_addr,
  input  logic [31:0]      i_d_wdata,
  input  logic [2:0]       i_d_op,
  output logic             o_d_ready,
  output logic             o_rsp_valid,
  output logic             o_rsp_id,
  output logic             o_rsp_err,
  output logic [31:0]      o_rsp_data,
  output logic [1:0]       o_ext_ad,
  output logic [2:0]       o_ext_op,
  output logic             o_mem_en,
  output logic [3:0]       o_mem_we,
  output logic [DM_AW-1:0] o_mem_addr,
  output logic [31:0]      o_mem_wdata,
  input  logic [31:0]      i_mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t           r_state;
  logic             r_last;
  logic             r_we;
  logic             r_id;
  logic             r_err;
  logic [1:0]       r_ad;
  logic [2:0]       r_op;
  logic             r_rsp_valid;
  logic             r_rsp_err;
  logic             r_mem_en;
  logic [3:0]       r_mem_we;
  logic [DM_AW-1:0] r_mem_addr;
  logic [31:0]      r_mem_wdata;

  logic        w_idle;
  logic        w_gnt_c;
  logic        w_gnt_d;
  logic        w_hs;
  logic        w_we;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [2:0]  w_op;
  logic        w_err;
  logic [3:0]  w_be;
  logic [31:0] w_wd;
  logic        w_unused;

  // Ready is gated by reset so nothing is
  // accepted while the block is held in reset.
  assign w_idle = (r_state == S_IDLE) & i_rst_n;

  // r_last: 0 = CPU granted last, 1 = bridge.
  // On a tie the side not granted last wins.
  assign w_gnt_c = w_idle & i_c_valid
                 & (~i_d_valid | r_last);
  assign w_gnt_d = w_idle & i_d_valid
                 & (~i_c_valid | ~r_last);
  assign w_hs    = w_gnt_c | w_gnt_d;

  assign o_c_ready = w_gnt_c;
  assign o_d_ready = w_gnt_d;

  assign w_we    = w_gnt_c ? i_c_we    : i_d_we;
  assign w_addr  = w_gnt_c ? i_c_addr  : i_d_addr;
  assign w_wdata = w_gnt_c ? i_c_wdata : i_d_wdata;
  assign w_op    = w_gnt_c ? i_c_op    : i_d_op;

  // Address bits above the memory are dropped.
  assign w_unused = &{1'b0, w_addr[31:DM_AW+2]};

  always_comb begin
    w_err = 1'b0;
    case (w_op)
      3'd0:       w_err = |w_addr[1:0];
      3'd1, 3'd2: w_err = 1'b0;
      3'd3, 3'd4: w_err = w_addr[0];
      default:    w_err = 1'b1;
    endcase
  end

  always_comb begin
    w_be = 4'b1111;
    w_wd = w_wdata;
    case (w_op)
      3'd1, 3'd2: begin
        w_be = 4'b0001 << w_addr[1:0];
        w_wd = {4{w_wdata[7:0]}};
      end
      3'd3, 3'd4: begin
        w_be = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wd = {2{w_wdata[15:0]}};
      end
      default: begin
        w_be = 4'b1111;
        w_wd = w_wdata;
      end
    endcase
    if (!w_we) w_be = 4'b0000;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;
      r_we        <= 1'b0;
      r_id        <= 1'b0;
      r_err       <= 1'b0;
      r_ad        <= 2'b00;
      r_op        <= 3'b000;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 4'b0000;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_we   <= w_we;
            r_id   <= w_gnt_d;
            r_last <= w_gnt_d;
            r_err  <= w_err;
            r_ad   <= w_addr[1:0];
            r_op   <= w_op;
            if (w_err) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else begin
              r_state     <= S_ACCESS;
              r_mem_en    <= 1'b1;
              r_mem_we    <= w_be;
              r_mem_addr  <= w_addr[DM_AW+1:2];
              r_mem_wdata <= w_wd;
            end
          end
        end
        S_ACCESS: begin
          r_state     <= S_RESP;
          r_mem_en    <= 1'b0;
          r_mem_we    <= 4'b0000;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_err   = r_rsp_err;
  assign o_rsp_id    = r_id;
  assign o_ext_ad    = r_ad;
  assign o_ext_op    = r_op;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

  // Read data arrives in RESP; stores and
  // errors return zero.
  assign o_rsp_data =
    (r_state == S_RESP && !r_we && !r_err)
      ? i_mem_rdata : 32'h0;

endmodule

// File: tb/tb_dm_arb.sv
// tb_dm_arb: randomized bench for dm_arb with a
// latency-based behavioural model and a RAM.
module tb_dm_arb;

  logic        clk;
  logic        rst_n = 1'b0;
  logic        c_valid = 1'b0;
  logic        c_we = 1'b0;
  logic [31:0] c_addr = '0;
  logic [31:0] c_wdata = '0;
  logic [2:0]  c_op = '0;
  logic        c_ready;
  logic        d_valid = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [2:0]  d_op = '0;
  logic        d_ready;
  logic        rsp_valid;
  logic        rsp_id;
  logic        rsp_err;
  logic [31:0] rsp_data;
  logic [1:0]  ext_ad;
  logic [2:0]  ext_op;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  dm_arb #(.DM_AW(12)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_c_valid(c_valid), .i_c_we(c_we),
    .i_c_addr(c_addr), .i_c_wdata(c_wdata),
    .i_c_op(c_op), .o_c_ready(c_ready),
    .i_d_valid(d_valid), .i_d_we(d_we),
    .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .i_d_op(d_op), .o_d_ready(d_ready),
    .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id),
    .o_rsp_err(rsp_err), .o_rsp_data(rsp_data),
    .o_ext_ad(ext_ad), .o_ext_op(ext_op),
    .o_mem_en(mem_en), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(int i);
    if (i == 4) return 32'h8899AABB;
    return 32'hCAFE0000 + i;
  endfunction

  // Environment RAM: filled on the first edge
  // (reset is held then), synchronous read.
  logic [31:0] mem [4096];
  bit env_init = 1'b0;
  always @(posedge clk) begin
    if (!env_init) begin
      for (int i = 0; i < 4096; i++)
        mem[i] <= pat(i);
      env_init <= 1'b1;
    end else if (mem_en) begin
      mem_rdata <= mem[mem_addr];
      for (int i = 0; i < 4; i++)
        if (mem_we[i])
          mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: one transaction record plus the cycle
  // it was accepted; everything else follows
  // from the documented latencies.
  logic [31:0] ref_mem [4096];
  logic        have;
  int          hs;
  int          cyc = 0;
  logic        m_last;
  logic [1:0]  m_ad;
  logic [2:0]  m_op;
  logic        t_id, t_we, t_err;
  logic [31:0] t_addr, t_wdata;
  logic [2:0]  t_op;

  function automatic int sz(input logic [2:0] op);
    if (op == 3'd0) return 4;
    if (op == 3'd1 || op == 3'd2) return 1;
    if (op == 3'd3 || op == 3'd4) return 2;
    return 4;
  endfunction

  function automatic int resp_cyc();
    return hs + (t_err ? 1 : 2);
  endfunction

  function automatic logic busy();
    return have && cyc <= resp_cyc();
  endfunction

  function automatic logic in_access();
    return have && !t_err && cyc == hs + 1;
  endfunction

  function automatic logic in_resp();
    return have && cyc == resp_cyc();
  endfunction

  function automatic logic exp_rc();
    return rst_n && !busy() && c_valid
           && (!d_valid || m_last);
  endfunction

  function automatic logic exp_rd();
    return rst_n && !busy() && d_valid
           && (!c_valid || !m_last);
  endfunction

  function automatic logic [3:0] exp_be();
    logic [3:0] be;
    int a;
    int s;
    a = int'(t_addr[1:0]);
    s = sz(t_op);
    be = 4'b0000;
    for (int i = 0; i < 4; i++)
      be[i] = t_we && i >= a && i < a + s;
    return be;
  endfunction

  function automatic logic [31:0] exp_wd();
    logic [31:0] wd;
    int s;
    s = sz(t_op);
    for (int i = 0; i < 4; i++)
      wd[8*i +: 8] = t_wdata[8*(i % s) +: 8];
    return wd;
  endfunction

  task automatic model_reset();
    have   = 1'b0;
    m_last = 1'b1;
    m_ad   = 2'b00;
    m_op   = 3'b000;
  endtask

  task automatic capture(input logic id,
                         input logic we,
                         input logic [31:0] a,
                         input logic [31:0] wd,
                         input logic [2:0] op);
    t_id    = id;
    t_we    = we;
    t_addr  = a;
    t_wdata = wd;
    t_op    = op;
    t_err   = op > 3'd4
           || (int'(a[1:0]) % sz(op)) != 0;
    hs      = cyc;
    have    = 1'b1;
    m_last  = id;
    m_ad    = a[1:0];
    m_op    = op;
  endtask

  task automatic model_update();
    logic [3:0]  be;
    logic [31:0] wd;
    if (rst_n) begin
      if (in_access() && t_we) begin
        be = exp_be();
        wd = exp_wd();
        for (int i = 0; i < 4; i++)
          if (be[i])
            ref_mem[t_addr[13:2]][8*i +: 8] = wd[8*i +: 8];
      end
      if (exp_rc())
        capture(1'b0, c_we, c_addr, c_wdata, c_op);
      else if (exp_rd())
        capture(1'b1, d_we, d_addr, d_wdata, d_op);
    end
    cyc++;
  endtask

  task automatic compare_ready();
    chk("c_ready", {31'b0, c_ready}, {31'b0, exp_rc()});
    chk("d_ready", {31'b0, d_ready}, {31'b0, exp_rd()});
  endtask

  task automatic compare_outputs();
    logic [31:0] ed;
    if (!rst_n) begin
      chk("rst_mem_en", {31'b0, mem_en}, 0);
      chk("rst_mem_we", {28'b0, mem_we}, 0);
      chk("rst_mem_addr", {20'b0, mem_addr}, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
      chk("rst_rsp_err", {31'b0, rsp_err}, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_ext", {27'b0, ext_ad, ext_op}, 0);
    end else begin
      chk("mem_en", {31'b0, mem_en},
          {31'b0, in_access()});
      if (in_access()) begin
        chk("mem_addr", {20'b0, mem_addr},
            {20'b0, t_addr[13:2]});
        chk("mem_we", {28'b0, mem_we},
            {28'b0, exp_be()});
        if (t_we)
          chk("mem_wdata", mem_wdata, exp_wd());
      end else begin
        chk("mem_we_idle", {28'b0, mem_we}, 0);
      end
      chk("rsp_valid", {31'b0, rsp_valid},
          {31'b0, in_resp()});
      if (in_resp()) begin
        ed = (t_we || t_err)
           ? 32'h0 : ref_mem[t_addr[13:2]];
        chk("rsp_id", {31'b0, rsp_id}, {31'b0, t_id});
        chk("rsp_err", {31'b0, rsp_err},
            {31'b0, t_err});
        chk("rsp_data", rsp_data, ed);
      end else begin
        chk("rsp_err_idle", {31'b0, rsp_err}, 0);
      end
      chk("ext_ad", {30'b0, ext_ad}, {30'b0, m_ad});
      chk("ext_op", {29'b0, ext_op}, {29'b0, m_op});
    end
  endtask

  task automatic tick();
    #1 compare_ready();
    @(posedge clk);
    model_update();
    #1 compare_outputs();
  endtask

  task automatic set_c(input logic v, input logic we,
                       input logic [31:0] a,
                       input logic [31:0] wd,
                       input logic [2:0] op);
    c_valid = v; c_we = we; c_addr = a;
    c_wdata = wd; c_op = op;
  endtask

  task automatic set_d(input logic v, input logic we,
                       input logic [31:0] a,
                       input logic [31:0] wd,
                       input logic [2:0] op);
    d_valid = v; d_we = we; d_addr = a;
    d_wdata = wd; d_op = op;
  endtask

  task automatic rand_req(output logic v,
                          output logic we,
                          output logic [31:0] a,
                          output logic [31:0] wd,
                          output logic [2:0] op);
    v  = $urandom_range(0, 3) != 0;
    we = $urandom_range(0, 1) == 1;
    a  = $urandom & 32'hFFFF_C03F;
    wd = $urandom;
    if ($urandom_range(0, 7) < 6)
      op = 3'($urandom_range(0, 4));
    else
      op = 3'($urandom_range(5, 7));
  endtask

  int          rcyc [$];
  logic        rids [$];
  logic        v, we;
  logic [31:0] a, wd;
  logic [2:0]  op;

  initial begin
    for (int i = 0; i < 4096; i++)
      ref_mem[i] = pat(i);
    model_reset();
    set_c(1'b1, 1'b0, 32'h10, 32'h0, 3'd0);
    repeat (3) tick();
    chk("rst_c_ready_held", {31'b0, c_ready}, 0);
    set_c(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    rst_n = 1'b1;

    // CPU lw 0x10
    set_c(1'b1, 1'b0, 32'h10, 32'h0, 3'd0);
    tick();
    set_c(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    chk("lw_mem_en", {31'b0, mem_en}, 1);
    chk("lw_mem_addr", {20'b0, mem_addr}, 4);
    tick();
    chk("lw_rsp_valid", {31'b0, rsp_valid}, 1);
    chk("lw_rsp_id", {31'b0, rsp_id}, 0);
    chk("lw_rsp_data", rsp_data, 32'h8899AABB);
    chk("lw_ext", {27'b0, ext_ad, ext_op}, 0);
    tick();

    // bridge sb 0x7
    set_d(1'b1, 1'b1, 32'h7, 32'h5A, 3'd1);
    tick();
    set_d(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    chk("sb_mem_we", {28'b0, mem_we}, 32'h8);
    chk("sb_mem_wdata", mem_wdata, 32'h5A5A5A5A);
    chk("sb_mem_addr", {20'b0, mem_addr}, 1);
    tick();
    chk("sb_rsp_valid", {31'b0, rsp_valid}, 1);
    chk("sb_rsp_id", {31'b0, rsp_id}, 1);
    chk("sb_rsp_data", rsp_data, 0);
    chk("sb_rsp_err", {31'b0, rsp_err}, 0);
    tick();

    // errors: misaligned lh, illegal op
    set_c(1'b1, 1'b0, 32'h3, 32'h0, 3'd4);
    tick();
    set_c(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    chk("lh3_mem_en", {31'b0, mem_en}, 0);
    chk("lh3_rsp_valid", {31'b0, rsp_valid}, 1);
    chk("lh3_rsp_err", {31'b0, rsp_err}, 1);
    chk("lh3_rsp_data", rsp_data, 0);
    tick();
    set_c(1'b1, 1'b0, 32'h0, 32'h0, 3'd6);
    tick();
    set_c(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    chk("op6_mem_en", {31'b0, mem_en}, 0);
    chk("op6_rsp_valid", {31'b0, rsp_valid}, 1);
    chk("op6_rsp_err", {31'b0, rsp_err}, 1);
    chk("op6_rsp_data", rsp_data, 0);
    tick();

    // round robin from reset
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    set_c(1'b1, 1'b0, 32'h20, 32'h0, 3'd0);
    set_d(1'b1, 1'b0, 32'h24, 32'h0, 3'd0);
    #1 chk("tie_first_c", {31'b0, c_ready}, 1);
    for (int i = 0; i < 14; i++) begin
      tick();
      if (rsp_valid === 1'b1) begin
        rcyc.push_back(cyc);
        rids.push_back(rsp_id);
      end
    end
    chk("tie_count", {31'b0, rcyc.size() >= 4}, 1);
    if (rcyc.size() >= 4)
      for (int i = 0; i < 4; i++) begin
        chk("tie_id", {31'b0, rids[i]}, i % 2);
        if (i > 0)
          chk("tie_gap", rcyc[i] - rcyc[i-1], 3);
      end
    set_c(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    set_d(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    repeat (3) tick();

    // sh 0x2 aborted by reset in ACCESS
    set_c(1'b1, 1'b1, 32'h2, 32'h1234, 3'd3);
    tick();
    set_c(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    chk("sh_mem_we", {28'b0, mem_we}, 32'hC);
    chk("sh_mem_wdata", mem_wdata, 32'h12341234);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("abort_mem_en", {31'b0, mem_en}, 0);
    chk("abort_mem_we", {28'b0, mem_we}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    set_c(1'b1, 1'b0, 32'h0, 32'h0, 3'd0);
    tick();
    set_c(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    tick();
    chk("abort_rsp_valid", {31'b0, rsp_valid}, 1);
    chk("abort_word0", rsp_data, 32'hCAFE0000);
    tick();

    // randomized traffic with rare resets
    for (int n = 0; n < 4000; n++) begin
      rand_req(v, we, a, wd, op);
      set_c(v, we, a, wd, op);
      rand_req(v, we, a, wd, op);
      set_d(v, we, a, wd, op);
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
